// File: rtl/mips_pkg.sv
// Shared definitions for the fetch/decode front end.
package mips_pkg;

    localparam logic [31:0] NOP_INST         = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        FETCH_REQ  = 1'b0,
        FETCH_HOLD = 1'b1
    } fetch_state_t;

    // Sequential PC step; wraps modulo 2^32.
    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/ifid_reg.sv
// Pipeline register carrying {instruction, PC+4, valid} into decode.
// flush wins over stall; a flush loads a NOP with valid cleared but keeps
// the supplied PC+4 so decode always sees a coherent PC.
module ifid_reg
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        stall,
    input  logic [31:0] inst_next,
    input  logic [31:0] pc_plus_4_next,
    input  logic        valid_next,
    output logic [31:0] inst,
    output logic [31:0] pc_plus_4,
    output logic        valid
);

    // Register update: reset, then flush, then stall, then load.
    always_ff @(posedge clk) begin
        if (!reset) begin
            inst      <= NOP_INST;
            pc_plus_4 <= 32'h0000_0000;
            valid     <= 1'b0;
        end else if (flush) begin
            inst      <= NOP_INST;
            pc_plus_4 <= pc_plus_4_next;
            valid     <= 1'b0;
        end else if (!stall) begin
            inst      <= inst_next;
            pc_plus_4 <= pc_plus_4_next;
            valid     <= valid_next;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch with a variable-latency instruction memory.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   FETCH_REQ  | request at pc_f outstanding, address held until imem_ready
//   FETCH_HOLD | word captured in hold_inst while decode is stalled; no request
//
// A redirect arriving while a request is outstanding is parked in redir_pc
// and applied when the in-flight word returns; that word is then dropped.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_src_D,
    input  logic [31:0] next_br_D,
    input  logic        stall_F,
    input  logic        stall_D,
    input  logic        flush_D,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] inst_D,
    output logic [31:0] PC_plus_4_D,
    output logic        valid_D,
    output logic        imem_busy_F
);

    fetch_state_t state, state_next;
    logic [31:0]  pc_f;
    logic [31:0]  pc_f_plus_4;
    logic [31:0]  hold_inst;
    logic [31:0]  redir_pc;
    logic         redir_pending;
    logic         completion;
    logic         redir_acc;
    logic         deliver;
    logic [31:0]  deliver_inst;

    assign pc_f_plus_4 = pc_inc(pc_f);
    assign completion  = (state == FETCH_REQ) && imem_ready;
    assign redir_acc   = pc_src_D && !stall_D;
    assign imem_addr   = pc_f;
    assign imem_busy_F = imem_req && !imem_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= FETCH_REQ;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: park a completed word only when decode cannot take it.
    always_comb begin
        state_next = state;
        case (state)
            FETCH_REQ: begin
                if (completion && !redir_acc && !redir_pending && stall_F) begin
                    state_next = FETCH_HOLD;
                end
            end
            FETCH_HOLD: begin
                if (redir_acc || !stall_F) begin
                    state_next = FETCH_REQ;
                end
            end
            default: state_next = FETCH_REQ;
        endcase
    end

    // Outputs: memory request and the instruction handed to IF/ID.
    always_comb begin
        imem_req     = (state == FETCH_REQ);
        deliver      = 1'b0;
        deliver_inst = NOP_INST;
        case (state)
            FETCH_REQ: begin
                deliver      = completion && !redir_acc && !redir_pending && !stall_F;
                deliver_inst = imem_rdata;
            end
            FETCH_HOLD: begin
                deliver      = !redir_acc && !stall_F;
                deliver_inst = hold_inst;
            end
            default: begin
                deliver      = 1'b0;
                deliver_inst = NOP_INST;
            end
        endcase
    end

    // PC, hold buffer and parked redirect.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_f          <= RESET_PC;
            hold_inst     <= NOP_INST;
            redir_pending <= 1'b0;
            redir_pc      <= 32'h0000_0000;
        end else if (state == FETCH_REQ) begin
            if (completion) begin
                if (redir_acc) begin
                    pc_f <= next_br_D;
                end else if (redir_pending) begin
                    pc_f <= redir_pc;
                end else if (!stall_F) begin
                    pc_f <= pc_f_plus_4;
                end else begin
                    hold_inst <= imem_rdata;
                end
                redir_pending <= 1'b0;
            end else if (redir_acc) begin
                redir_pending <= 1'b1;
                redir_pc      <= next_br_D;
            end
        end else begin
            if (redir_acc) begin
                pc_f <= next_br_D;
            end else if (!stall_F) begin
                pc_f <= pc_f_plus_4;
            end
        end
    end

    ifid_reg u_ifid_reg (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush_D),
        .stall          (stall_D),
        .inst_next      (deliver ? deliver_inst : NOP_INST),
        .pc_plus_4_next (pc_f_plus_4),
        .valid_next     (deliver),
        .inst           (inst_D),
        .pc_plus_4      (PC_plus_4_D),
        .valid          (valid_D)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, hand-written corner
// sequences, then randomized traffic against a transaction-level model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_src_D;
    logic [31:0] next_br_D;
    logic        stall_F;
    logic        stall_D;
    logic        flush_D;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] inst_D;
    logic [31:0] PC_plus_4_D;
    logic        valid_D;
    logic        imem_busy_F;

    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

    fetch_stage dut (
        .clk         (clk),
        .reset       (reset),
        .pc_src_D    (pc_src_D),
        .next_br_D   (next_br_D),
        .stall_F     (stall_F),
        .stall_D     (stall_D),
        .flush_D     (flush_D),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ready  (imem_ready),
        .inst_D      (inst_D),
        .PC_plus_4_D (PC_plus_4_D),
        .valid_D     (valid_D),
        .imem_busy_F (imem_busy_F)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Instruction memory contents: distinct word per address.
    function automatic logic [31:0] memw(input logic [31:0] a);
        return a ^ 32'h5A3C_96E1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // One clock: drive inputs on the falling edge, check the combinational
    // memory-side outputs, then check IF/ID after the rising edge.
    task automatic cyc(input string tag, input logic rst, input logic src,
                       input logic [31:0] br, input logic sf, input logic sd,
                       input logic fl, input logic rdy, input logic [31:0] rd,
                       input logic e_req, input logic [31:0] e_addr, input logic e_busy,
                       input logic [31:0] e_inst, input logic [31:0] e_pc4,
                       input logic e_valid);
        @(negedge clk);
        reset      = rst;
        pc_src_D   = src;
        next_br_D  = br;
        stall_F    = sf;
        stall_D    = sd;
        flush_D    = fl;
        imem_ready = rdy;
        imem_rdata = rd;
        #1;
        chk({tag, ".imem_req"},    {31'b0, imem_req},    {31'b0, e_req});
        chk({tag, ".imem_addr"},   imem_addr,            e_addr);
        chk({tag, ".imem_busy_F"}, {31'b0, imem_busy_F}, {31'b0, e_busy});
        @(posedge clk);
        #1;
        chk({tag, ".inst_D"},      inst_D,               e_inst);
        chk({tag, ".PC_plus_4_D"}, PC_plus_4_D,          e_pc4);
        chk({tag, ".valid_D"},     {31'b0, valid_D},     {31'b0, e_valid});
    endtask

    typedef struct {
        logic        src;
        logic [31:0] br;
        logic        sf, sd, fl, rdy;
        logic [31:0] rd;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_busy;
        logic [31:0] e_inst, e_pc4;
        logic        e_valid;
    } vec_t;

    function automatic vec_t mk(input logic src, input logic [31:0] br, input logic sf,
                                input logic sd, input logic fl, input logic rdy,
                                input logic [31:0] rd, input logic e_req,
                                input logic [31:0] e_addr, input logic e_busy,
                                input logic [31:0] e_inst, input logic [31:0] e_pc4,
                                input logic e_valid);
        vec_t v;
        v.src = src; v.br = br; v.sf = sf; v.sd = sd; v.fl = fl; v.rdy = rdy; v.rd = rd;
        v.e_req = e_req; v.e_addr = e_addr; v.e_busy = e_busy;
        v.e_inst = e_inst; v.e_pc4 = e_pc4; v.e_valid = e_valid;
        return v;
    endfunction

    // Reference model state (transaction level).
    logic [31:0] m_pc, m_word, m_inst, m_pc4;
    logic        m_parked, m_valid;
    logic [31:0] m_redir_q[$];

    task automatic model_step(input logic rst, input logic src, input logic [31:0] br,
                              input logic sf, input logic sd, input logic fl,
                              input logic rdy, input logic [31:0] rd);
        logic [31:0] old_pc4;
        logic        deliv;
        logic [31:0] dw;
        logic        acc;
        old_pc4 = m_pc + 32'd4;
        deliv   = 1'b0;
        dw      = 32'h0;
        acc     = src && !sd;
        if (!rst) begin
            m_pc = 32'h0; m_parked = 1'b0; m_word = 32'h0; m_redir_q.delete();
            m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        end else begin
            if (m_parked) begin
                if (acc) begin
                    m_pc = br; m_parked = 1'b0;
                end else if (!sf) begin
                    deliv = 1'b1; dw = m_word; m_pc = old_pc4; m_parked = 1'b0;
                end
            end else if (rdy) begin
                if (acc) begin
                    m_pc = br; m_redir_q.delete();
                end else if (m_redir_q.size() > 0) begin
                    m_pc = m_redir_q.pop_front();
                end else if (!sf) begin
                    deliv = 1'b1; dw = rd; m_pc = old_pc4;
                end else begin
                    m_parked = 1'b1; m_word = rd;
                end
            end else if (acc) begin
                m_redir_q.delete();
                m_redir_q.push_back(br);
            end
            if (fl) begin
                m_inst = 32'h0; m_pc4 = old_pc4; m_valid = 1'b0;
            end else if (!sd) begin
                m_inst = deliv ? dw : 32'h0; m_pc4 = old_pc4; m_valid = deliv;
            end
        end
    endtask

    vec_t tbl[15];

    initial begin
        reset = 1'b0; pc_src_D = 1'b0; next_br_D = 32'h0; stall_F = 1'b0;
        stall_D = 1'b0; flush_D = 1'b0; imem_ready = 1'b0; imem_rdata = 32'h0;

        tbl[0]  = mk(0, 0, 0, 0, 0, 1, memw(0),      1, 32'h0,   0, memw(0),      32'h4,   1);
        tbl[1]  = mk(0, 0, 0, 0, 0, 1, memw(4),      1, 32'h4,   0, memw(4),      32'h8,   1);
        tbl[2]  = mk(0, 0, 0, 0, 0, 1, memw(8),      1, 32'h8,   0, memw(8),      32'hC,   1);
        tbl[3]  = mk(0, 0, 0, 0, 0, 0, JUNK,         1, 32'hC,   1, 32'h0,        32'h10,  0);
        tbl[4]  = mk(0, 0, 0, 0, 0, 0, JUNK,         1, 32'hC,   1, 32'h0,        32'h10,  0);
        tbl[5]  = mk(0, 0, 0, 0, 0, 1, memw(12),     1, 32'hC,   0, memw(12),     32'h10,  1);
        tbl[6]  = mk(0, 0, 1, 1, 1, 0, JUNK,         1, 32'h10,  1, 32'h0,        32'h14,  0);
        tbl[7]  = mk(0, 0, 1, 1, 0, 1, memw(16),     1, 32'h10,  0, 32'h0,        32'h14,  0);
        tbl[8]  = mk(0, 0, 1, 1, 0, 1, JUNK,         0, 32'h10,  0, 32'h0,        32'h14,  0);
        tbl[9]  = mk(0, 0, 0, 0, 0, 1, JUNK,         0, 32'h10,  0, memw(16),     32'h14,  1);
        tbl[10] = mk(1, 32'h100, 0, 0, 0, 0, JUNK,   1, 32'h14,  1, 32'h0,        32'h18,  0);
        tbl[11] = mk(0, 0, 0, 0, 0, 1, memw(20),     1, 32'h14,  0, 32'h0,        32'h18,  0);
        tbl[12] = mk(0, 0, 0, 0, 0, 1, memw(32'h100), 1, 32'h100, 0, memw(32'h100), 32'h104, 1);
        tbl[13] = mk(1, 32'h200, 0, 0, 0, 1, memw(32'h104), 1, 32'h104, 0, 32'h0, 32'h108, 0);
        tbl[14] = mk(0, 0, 0, 0, 0, 0, JUNK,         1, 32'h200, 1, 32'h0,        32'h204, 0);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("reset.imem_req",    {31'b0, imem_req},    32'h1);
        chk("reset.imem_addr",   imem_addr,            32'h0);
        chk("reset.imem_busy_F", {31'b0, imem_busy_F}, 32'h1);
        chk("reset.inst_D",      inst_D,               32'h0);
        chk("reset.PC_plus_4_D", PC_plus_4_D,          32'h0);
        chk("reset.valid_D",     {31'b0, valid_D},     32'h0);

        for (int i = 0; i < 15; i++) begin
            cyc($sformatf("vec%0d", i), 1'b1, tbl[i].src, tbl[i].br, tbl[i].sf, tbl[i].sd,
                tbl[i].fl, tbl[i].rdy, tbl[i].rd, tbl[i].e_req, tbl[i].e_addr, tbl[i].e_busy,
                tbl[i].e_inst, tbl[i].e_pc4, tbl[i].e_valid);
        end

        // Wait states at 0x10.
        cyc("ws.redir", 1, 1, 32'h10, 0, 0, 0, 1, memw(32'h200), 1, 32'h200, 0, 32'h0, 32'h204, 0);
        for (int i = 0; i < 3; i++) begin
            cyc($sformatf("ws.wait%0d", i), 1, 0, 0, 0, 0, 0, 0, JUNK, 1, 32'h10, 1, 32'h0, 32'h14, 0);
        end
        cyc("ws.done", 1, 0, 0, 0, 0, 0, 1, memw(32'h10), 1, 32'h10, 0, memw(32'h10), 32'h14, 1);

        // Completion at 0x20 under stall: hold, then release without re-fetch.
        cyc("hold.redir", 1, 1, 32'h20, 0, 0, 0, 1, memw(32'h14), 1, 32'h14, 0, 32'h0, 32'h18, 0);
        cyc("hold.cap",   1, 0, 0, 1, 1, 0, 1, memw(32'h20), 1, 32'h20, 0, 32'h0, 32'h18, 0);
        cyc("hold.stall", 1, 0, 0, 1, 1, 0, 1, JUNK, 0, 32'h20, 0, 32'h0, 32'h18, 0);
        cyc("hold.rel",   1, 0, 0, 0, 0, 0, 1, JUNK, 0, 32'h20, 0, memw(32'h20), 32'h24, 1);

        // Redirect while fetch of 0x40 waits.
        cyc("br.to40",  1, 1, 32'h40, 0, 0, 0, 1, memw(32'h24), 1, 32'h24, 0, 32'h0, 32'h28, 0);
        cyc("br.park",  1, 1, 32'h100, 0, 0, 0, 0, JUNK, 1, 32'h40, 1, 32'h0, 32'h44, 0);
        cyc("br.drop",  1, 0, 0, 0, 0, 0, 1, memw(32'h40), 1, 32'h40, 0, 32'h0, 32'h44, 0);
        cyc("br.tgt",   1, 0, 0, 0, 0, 0, 0, JUNK, 1, 32'h100, 1, 32'h0, 32'h104, 0);

        // Flush under stall, and PC wrap.
        cyc("wrap.redir", 1, 1, 32'hFFFF_FFF8, 0, 0, 0, 1, JUNK, 1, 32'h100, 0, 32'h0, 32'h104, 0);
        cyc("wrap.f8",    1, 0, 0, 0, 0, 0, 1, memw(32'hFFFF_FFF8), 1, 32'hFFFF_FFF8, 0,
            memw(32'hFFFF_FFF8), 32'hFFFF_FFFC, 1);
        cyc("flush.stall", 1, 0, 0, 1, 1, 1, 0, JUNK, 1, 32'hFFFF_FFFC, 1, 32'h0, 32'h0, 0);
        cyc("wrap.fc",    1, 0, 0, 0, 0, 0, 1, memw(32'hFFFF_FFFC), 1, 32'hFFFF_FFFC, 0,
            memw(32'hFFFF_FFFC), 32'h0, 1);
        cyc("wrap.zero",  1, 0, 0, 0, 0, 0, 0, JUNK, 1, 32'h0, 1, 32'h0, 32'h4, 0);

        // Reset in the middle of an outstanding request.
        cyc("mrst.redir", 1, 1, 32'h300, 0, 0, 0, 1, JUNK, 1, 32'h0, 0, 32'h0, 32'h4, 0);
        cyc("mrst.rst",   0, 0, 0, 0, 0, 0, 0, JUNK, 1, 32'h300, 1, 32'h0, 32'h0, 0);
        cyc("mrst.after", 1, 0, 0, 0, 0, 0, 0, JUNK, 1, 32'h0, 1, 32'h0, 32'h4, 0);

        // Randomized traffic against the model.
        m_pc = 32'h0; m_word = 32'h0; m_inst = 32'h0; m_pc4 = 32'h0;
        m_parked = 1'b0; m_valid = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            logic        r_rst, r_src, r_sf, r_sd, r_fl, r_rdy;
            logic [31:0] r_br, r_rd;
            logic        e_req, e_busy;
            logic [31:0] e_addr;
            r_rst = !((n == 0) || ($urandom_range(0, 79) == 0));
            r_sd  = ($urandom_range(0, 4) == 0);
            r_sf  = r_sd || ($urandom_range(0, 5) == 0);
            r_fl  = ($urandom_range(0, 7) == 0);
            r_src = ($urandom_range(0, 5) == 0);
            r_br  = $urandom() & 32'hFFFF_FFFC;
            r_rdy = ($urandom_range(0, 9) < 6);
            r_rd  = $urandom();
            e_req  = !m_parked;
            e_addr = m_pc;
            e_busy = e_req && !r_rdy;
            model_step(r_rst, r_src, r_br, r_sf, r_sd, r_fl, r_rdy, r_rd);
            if (n == 0) begin
                // State before the first reset is the directed phase's; skip pre-edge checks.
                @(negedge clk);
                reset = r_rst; pc_src_D = r_src; next_br_D = r_br; stall_F = r_sf;
                stall_D = r_sd; flush_D = r_fl; imem_ready = r_rdy; imem_rdata = r_rd;
                @(posedge clk);
                #1;
                chk("rnd0.inst_D", inst_D, m_inst);
            end else begin
                cyc($sformatf("rnd%0d", n), r_rst, r_src, r_br, r_sf, r_sd, r_fl, r_rdy, r_rd,
                    e_req, e_addr, e_busy, m_inst, m_pc4, m_valid);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low (0 = reset), sampled on rising clk.
REQ-004 pc_src_D  input  1  decode requests redirect (taken branch/jump).
REQ-005 next_br_D  input  32  redirect target from decode.
REQ-006 stall_F  input  1  hold PC_F; hazard unit SHALL assert it whenever stall_D is 1.
REQ-007 stall_D  input  1  hold IF/ID register.
REQ-008 flush_D  input  1  load bubble into IF/ID.
REQ-009 imem_req  output  1  instruction-memory request valid.
REQ-010 imem_addr  output  32  fetch address, equals PC_F.
REQ-011 imem_rdata  input  32  instruction word, valid when imem_ready is 1.
REQ-012 imem_ready  input  1  completes request in the cycle it is high while imem_req is 1.
REQ-013 inst_D  output  32  IF/ID instruction to decode.
REQ-014 PC_plus_4_D  output  32  IF/ID PC+4 to decode.
REQ-015 valid_D  output  1  inst_D holds a real instruction.
REQ-016 imem_busy_F  output  1  imem_req && !imem_ready, to hazard unit.

Function
REQ-017 Registers: PC_F, state {REQ, HOLD}, hold_inst (32), redir_pending, redir_pc (32), IF/ID {inst_D, PC_plus_4_D, valid_D}.
REQ-018 REQ state: imem_req=1, imem_addr=PC_F; address stable until completion; imem_ready ignored when imem_req=0.
REQ-019 Redirect accepted when pc_src_D=1 and stall_D=0; fetched word for current PC_F is discarded (no delay slot).
REQ-020 REQ, completion, no redirect (accepted or pending), stall_F=0: IF/ID <= {imem_rdata, PC_F+4, 1}; PC_F <= PC_F+4; stay REQ; zero-wait throughput one instruction per cycle.
REQ-021 REQ, completion, stall_F=1, no redirect: hold_inst <= imem_rdata; go HOLD; IF/ID unchanged.
REQ-022 REQ, no completion, accepted redirect: redir_pending <= 1, redir_pc <= next_br_D; PC_F unchanged while request outstanding.
REQ-023 REQ, completion with redir_pending=1 or accepted redirect same cycle: discard word; PC_F <= accepted target if present else redir_pc; redir_pending <= 0; stay REQ.
REQ-024 HOLD: imem_req=0; when stall_F=0: IF/ID <= {hold_inst, PC_F+4, 1}, PC_F <= PC_F+4, go REQ.
REQ-025 HOLD with accepted redirect: discard hold_inst, PC_F <= next_br_D, go REQ.
REQ-026 Whenever no instruction is delivered and stall_D=0, IF/ID <= bubble {32'h0000_0000, PC_F+4, 0}.
REQ-027 Priority on IF/ID: flush_D > stall_D > deliver/bubble; flush_D loads bubble even when stall_D=1.
REQ-028 PC arithmetic modulo 2^32: PC_F=32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-029 imem_busy_F is combinational; all other outputs registered.

Reset
REQ-030 On reset=0 at rising clk: PC_F=RESET_PC, state=REQ, redir_pending=0, redir_pc=0, hold_inst=0, inst_D=0, PC_plus_4_D=0, valid_D=0.
REQ-031 Reset mid-request abandons it; first cycle after reset presents imem_addr=RESET_PC with imem_req=1.

Structure
REQ-032 Shared package mips_pkg holds NOP_INST (32'h0), state enum for REQ/HOLD, RESET_PC default.
REQ-033 One sub-module ifid_reg: IF/ID register with flush and stall enables, reused by later pipeline registers.

Verification
REQ-034 Reset, imem_ready=1 always: imem_addr 0,4,8 on consecutive cycles; inst_D follows one cycle later, valid_D=1.
REQ-035 Fetch at 0x10 with imem_ready low 3 cycles: imem_busy_F=1 three cycles, imem_addr held 0x10, three bubbles (valid_D=0) into decode.
REQ-036 Completion at 0x20 while stall_F=stall_D=1 for 2 cycles: enter HOLD, imem_req=0; after release inst_D=word@0x20, PC_plus_4_D=0x24, no re-fetch of 0x20.
REQ-037 pc_src_D=1, next_br_D=0x100 while fetch of 0x40 waits: word@0x40 discarded on arrival, next imem_addr=0x100, valid_D=0 for discarded slot.
REQ-038 flush_D=1 with stall_D=1: inst_D=0, valid_D=0 next cycle; PC_F=0xFFFF_FFFC completes -> next imem_addr=0x0.
